fact_mmio: RTL



---
 rtl/fact_pkg.sv | 16 +
 rtl/fact_core.sv | 88 ++++++++
 rtl/fact_mmio.sv | 77 +++++++
 3 files changed

// File: rtl/fact_pkg.sv
// Shared constants and types for the memory-mapped factorial accelerator.
package fact_pkg;

  localparam logic [3:0] OFF_N      = 4'h0;
  localparam logic [3:0] OFF_GO     = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_RESULT = 4'hC;

  localparam int unsigned MAX_N_DEF = 12;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

endpackage

// File: rtl/fact_core.sv
// Iterative n! engine, one multiply per clock; done rises max(n,1) edges after start.
// No backpressure: a start while busy is dropped and status is left untouched.
module fact_core
  import fact_pkg::*;
#(
  parameter int unsigned MAX_N = MAX_N_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  n,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result
);

  localparam logic [3:0] MAX_N4 = 4'(MAX_N);

  state_e      state_q, state_d;
  logic [31:0] prod_q, prod_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] result_q, result_d;

  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          if (n > MAX_N4) begin
            // Out-of-range n reports completion with error in one edge.
            err_d    = 1'b1;
            done_d   = 1'b1;
            result_d = '0;
          end else begin
            prod_d  = 32'd1;
            cnt_d   = n;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (cnt_q <= 4'd1) begin
          result_d = prod_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          prod_d = prod_q * {28'd0, cnt_q};
          cnt_d  = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      prod_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == CALC);
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: rtl/fact_mmio.sv
// Factorial accelerator on the core data-memory bus: 16-byte register window, zero-latency readback.
// No backpressure: window stores are absorbed here and never reach data memory.
module fact_mmio
  import fact_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0800,
  parameter int unsigned MAX_N     = MAX_N_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic [31:0] rd_dmem,
  output logic        we_dmem,
  output logic [31:0] rd,
  output logic        busy
);

  logic        hit;
  logic [3:0]  off;
  logic [3:0]  n_q, n_d;
  logic        start;
  logic        done;
  logic        err;
  logic [31:0] result;
  logic [31:0] reg_rdata;

  assign hit = (a[31:4] == BASE_ADDR[31:4]);
  // Byte lane bits are don't-care; registers are word aligned.
  assign off = 4'(a) & 4'hC;

  assign we_dmem = we & ~hit;
  assign start   = we & hit & (off == OFF_GO) & wd[0];

  always_comb begin
    n_d = n_q;
    if (we && hit && (off == OFF_N)) begin
      n_d = 4'(wd);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q <= '0;
    end else begin
      n_q <= n_d;
    end
  end

  fact_core #(
    .MAX_N (MAX_N)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .n      (n_q),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result)
  );

  always_comb begin
    reg_rdata = '0;
    case (off)
      OFF_N:      reg_rdata = {28'd0, n_q};
      OFF_GO:     reg_rdata = {31'd0, busy};
      OFF_STATUS: reg_rdata = {30'd0, err, done};
      OFF_RESULT: reg_rdata = result;
      default:    reg_rdata = '0;
    endcase
  end

  assign rd = hit ? reg_rdata : rd_dmem;

endmodule
